// File: rtl/uart_frame_parser.sv
// uart_frame_parser: byte framer behind the UART receiver (HDR0 HDR1 LEN CMD PAYLOAD CSUM).
// Optional inter-byte timeout is built only when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter logic [7:0]  HDR0        = 8'h55,
  parameter logic [7:0]  HDR1        = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 52_080
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rx_done,
  input  logic [7:0]        uart_rx_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [7:0]        good_cnt
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LEN,
    S_CMD,
    S_DATA,
    S_CSUM
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rx_done_q;
  logic              byte_stb;
  logic [7:0]        len_q;
  logic [7:0]        len_nxt;
  logic [7:0]        cmd_q;
  logic [7:0]        cmd_nxt;
  logic [7:0]        sum_q;
  logic [7:0]        sum_nxt;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_nxt;
  logic              wr_en;
  logic              valid_nxt;
  logic              err_nxt;
  logic [1:0]        code_nxt;
  logic              timeout;
  logic [7:0]        mem [MAX_LEN];

  assign byte_stb = uart_rx_done & ~rx_done_q;
  assign busy     = (state != S_HDR0);

  // Edge detect on the receiver's byte-ready level
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rx_done_q <= 1'b0;
    else            rx_done_q <= uart_rx_done;
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt;

  assign timeout = busy && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle-cycle counter, restarted by every byte and while parked in S_HDR0
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              to_cnt <= '0;
    else if (byte_stb || !busy)  to_cnt <= '0;
    else                         to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Frame state and running checksum registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_HDR0;
      len_q <= 8'h00;
      cmd_q <= 8'h00;
      sum_q <= 8'h00;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      len_q <= len_nxt;
      cmd_q <= cmd_nxt;
      sum_q <= sum_nxt;
      idx_q <= idx_nxt;
    end
  end

  // Next-state decode; a byte always takes priority over a timeout
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    cmd_nxt   = cmd_q;
    sum_nxt   = sum_q;
    idx_nxt   = idx_q;
    wr_en     = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    if (byte_stb) begin
      unique case (state)
        S_HDR0: begin
          if (uart_rx_data == HDR0) state_nxt = S_HDR1;
        end
        S_HDR1: begin
          if (uart_rx_data == HDR1)      state_nxt = S_LEN;
          else if (uart_rx_data == HDR0) state_nxt = S_HDR1;
          else                           state_nxt = S_HDR0;
        end
        S_LEN: begin
          if (uart_rx_data == 8'h00 ||
              32'(uart_rx_data) > MAX_LEN) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'd2;
            state_nxt = S_HDR0;
          end else begin
            len_nxt   = uart_rx_data;
            sum_nxt   = uart_rx_data;
            state_nxt = S_CMD;
          end
        end
        S_CMD: begin
          cmd_nxt   = uart_rx_data;
          sum_nxt   = sum_q + uart_rx_data;
          idx_nxt   = '0;
          state_nxt = S_DATA;
        end
        S_DATA: begin
          wr_en   = 1'b1;
          sum_nxt = sum_q + uart_rx_data;
          idx_nxt = idx_q + 1'b1;
          if (8'(idx_q) == len_q - 8'd1) state_nxt = S_CSUM;
        end
        S_CSUM: begin
          if (uart_rx_data == sum_q) begin
            valid_nxt = 1'b1;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = 2'd1;
          end
          state_nxt = S_HDR0;
        end
        default: state_nxt = S_HDR0;
      endcase
    end else if (timeout) begin
      err_nxt   = 1'b1;
      code_nxt  = 2'd3;
      state_nxt = S_HDR0;
    end
  end

  // Result pulses and last-good-frame registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      frame_cmd   <= 8'h00;
      frame_len   <= 8'h00;
      good_cnt    <= 8'h00;
    end else begin
      frame_valid <= valid_nxt;
      frame_err   <= err_nxt;
      err_code    <= code_nxt;
      if (valid_nxt) begin
        frame_cmd <= cmd_q;
        frame_len <= len_q;
        good_cnt  <= good_cnt + 8'd1;
      end
    end
  end

  // Payload buffer write port, fed only from S_DATA
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[idx_q[AW-1:0]] <= uart_rx_data;
  end

  // Registered read port; addresses past the buffer read as zero
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                  rd_data <= 8'h00;
    else if (32'(rd_addr) < MAX_LEN) rd_data <= mem[rd_addr[AW-1:0]];
    else                             rd_data <= 8'h00;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed frames against a queue-based frame model.
// Per-cycle compare of pulses, last-frame registers, busy; literal spot checks.
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         ADDR_W  = 5;
  localparam int         TO      = 3000;
  localparam logic [7:0] HDR0    = 8'h55;
  localparam logic [7:0] HDR1    = 8'hAA;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              uart_rx_done = 1'b0;
  logic [7:0]        uart_rx_data = 8'h00;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              frame_valid;
  logic [7:0]        frame_cmd;
  logic [7:0]        frame_len;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;
  logic [7:0]        good_cnt;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .HDR0(HDR0),
    .HDR1(HDR1), .TIMEOUT_CYC(TO)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd),
    .frame_len(frame_len), .frame_err(frame_err),
    .err_code(err_code), .busy(busy), .good_cnt(good_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // model: pending bytes of the frame being assembled
  logic [7:0] q[$];
  logic       has_exp = 1'b0;
  int         exp_cyc = 0;
  int         exp_kind = 0;
  logic [1:0] exp_code = 2'd0;
  logic [7:0] exp_cmd = 8'h00;
  logic [7:0] exp_len = 8'h00;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_pay [16];

  logic       m_busy = 1'b0;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_len = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  logic [1:0] m_code = 2'd0;
  int         m_last = 0;
  logic [7:0] m_pay [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    logic [7:0] s;
    int n;
    q.push_back(b);
    exp_kind = 0;
    exp_code = 2'd0;
    n = q.size();
    if (q[0] != HDR0) begin
      q.delete();
    end else if (n == 2 && q[1] != HDR1) begin
      if (q[1] == HDR0) void'(q.pop_front());
      else q.delete();
    end else if (n == 3 && (q[2] == 8'h00 || int'(q[2]) > MAX_LEN)) begin
      exp_kind = 2;
      exp_code = 2'd2;
      q.delete();
    end else if (n >= 3 && n == int'(q[2]) + 5) begin
      s = 8'h00;
      for (int i = 2; i < n - 1; i++) s = s + q[i];
      if (s == q[n-1]) begin
        exp_kind = 1;
        exp_cmd  = q[3];
        exp_len  = q[2];
        for (int i = 0; i < int'(q[2]); i++) exp_pay[i] = q[4+i];
      end else begin
        exp_kind = 2;
        exp_code = 2'd1;
      end
      q.delete();
    end
    exp_busy = (q.size() != 0);
    exp_cyc  = cyc + 1;
    has_exp  = 1'b1;
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin : cmp
    logic ev_v;
    logic ev_e;
    ev_v = 1'b0;
    ev_e = 1'b0;
    if (!rst_n) begin
      has_exp = 1'b0;
      m_busy = 1'b0;
      m_cmd = 8'h00;
      m_len = 8'h00;
      m_cnt = 8'h00;
      m_code = 2'd0;
    end else if (has_exp && cyc == exp_cyc) begin
      has_exp = 1'b0;
      m_busy = exp_busy;
      m_last = cyc;
      if (exp_kind == 1) begin
        ev_v = 1'b1;
        m_cmd = exp_cmd;
        m_len = exp_len;
        m_cnt = m_cnt + 8'd1;
        m_pay = exp_pay;
      end else if (exp_kind == 2) begin
        ev_e = 1'b1;
        m_code = exp_code;
      end
    end
`ifdef UART_FRAME_TIMEOUT_EN
    else if (m_busy && cyc == m_last + TO) begin
      ev_e = 1'b1;
      m_code = 2'd3;
      m_busy = 1'b0;
      q.delete();
    end
`endif
    chk("frame_valid", 32'(frame_valid), 32'(ev_v));
    chk("frame_err", 32'(frame_err), 32'(ev_e));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("frame_cmd", 32'(frame_cmd), 32'(m_cmd));
    chk("frame_len", 32'(frame_len), 32'(m_len));
    chk("good_cnt", 32'(good_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_busy));
    if (frame_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic send(input logic [7:0] b, input int hold);
    @(posedge clk);
    #1;
    model_push(b);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    repeat (hold) @(posedge clk);
    #1;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'h00;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_seq(input logic [7:0] bs[$], input int hold);
    foreach (bs[i]) send(bs[i], hold);
  endtask

  task automatic rd_chk(input int a, input logic [7:0] req);
    @(posedge clk);
    #1;
    rd_addr = ADDR_W'(a);
    @(posedge clk);
    #1;
    chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(req));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst frame_cmd", 32'(frame_cmd), 0);
    chk("rst good_cnt", 32'(good_cnt), 0);
    chk("rst err_code", 32'(err_code), 0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] fr[$];
    int v0;
    int e0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init rd_data", 32'(rd_data), 0);
    chk("init good_cnt", 32'(good_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // good frame, long byte-ready levels
    v0 = n_valid; e0 = n_err;
    fr = '{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01, 8'h02, 8'h03, 8'h19};
    send_seq(fr, 2604);
    chk("good n_valid", 32'(n_valid - v0), 1);
    chk("good n_err", 32'(n_err - e0), 0);
    chk("good cmd", 32'(frame_cmd), 32'h10);
    chk("good len", 32'(frame_len), 3);
    chk("good cnt", 32'(good_cnt), 1);
    rd_chk(0, 8'h01);
    rd_chk(1, 8'h02);
    rd_chk(2, 8'h03);
    rd_chk(1, m_pay[1]);
    rd_chk(16, 8'h00);
    rd_chk(31, 8'h00);

    // bad checksum
    v0 = n_valid; e0 = n_err;
    fr = '{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01, 8'h02, 8'h03, 8'h18};
    send_seq(fr, 3);
    chk("csum n_err", 32'(n_err - e0), 1);
    chk("csum n_valid", 32'(n_valid - v0), 0);
    chk("csum code", 32'(err_code), 1);
    chk("csum cmd", 32'(frame_cmd), 32'h10);
    chk("csum cnt", 32'(good_cnt), 1);

    // bad lengths: zero and MAX_LEN+1
    e0 = n_err;
    fr = '{8'h55, 8'hAA, 8'h00, 8'h55, 8'hAA, 8'h11};
    send_seq(fr, 1);
    chk("len n_err", 32'(n_err - e0), 2);
    chk("len code", 32'(err_code), 2);
    chk("len busy", 32'(busy), 0);

    // noise and header resync
    v0 = n_valid;
    fr = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h20, 8'h7F, 8'hA0};
    send_seq(fr, 2);
    chk("sync n_valid", 32'(n_valid - v0), 1);
    chk("sync cmd", 32'(frame_cmd), 32'h20);
    chk("sync len", 32'(frame_len), 1);
    chk("sync cnt", 32'(good_cnt), 2);
    rd_chk(0, 8'h7F);

    // reset in the middle of a frame
    fr = '{8'h55, 8'hAA, 8'h03, 8'h10};
    send_seq(fr, 2);
    chk("mid busy", 32'(busy), 1);
    v0 = n_valid; e0 = n_err;
    do_reset(4);
    repeat (2) @(posedge clk);
    fr = '{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01, 8'h02, 8'h03, 8'h19};
    send_seq(fr, 2);
    chk("rst n_valid", 32'(n_valid - v0), 1);
    chk("rst n_err", 32'(n_err - e0), 0);
    chk("rst cnt", 32'(good_cnt), 1);

    // stall after LEN
    e0 = n_err;
    fr = '{8'h55, 8'hAA, 8'h02};
    send_seq(fr, 2);
    repeat (TO + 20) @(posedge clk);
    #1;
`ifdef UART_FRAME_TIMEOUT_EN
    chk("to n_err", 32'(n_err - e0), 1);
    chk("to code", 32'(err_code), 3);
    chk("to busy", 32'(busy), 0);
`else
    chk("to n_err", 32'(n_err - e0), 0);
    chk("to busy", 32'(busy), 1);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
